// File: rtl/piece_queue_if.sv
// Generator/controller-facing bus of the next-piece queue.
// master: generator + game controller side; slave: the queue itself.
interface piece_queue_if #(
    parameter int unsigned CNT_W = 3
);
    logic             in_valid;
    logic [2:0]       in_type;
    logic [3:0]       in_x;
    logic [3:0]       in_y;
    logic             in_ready;
    logic             pop;
    logic             out_valid;
    logic [2:0]       out_type;
    logic [3:0]       out_x;
    logic [3:0]       out_y;
    logic             preview_valid;
    logic [2:0]       preview_type;
    logic [CNT_W-1:0] count;
    logic [7:0]       reject_cnt;

    modport master (
        output in_valid, in_type, in_x, in_y, pop,
        input  in_ready, out_valid, out_type, out_x, out_y,
               preview_valid, preview_type, count, reject_cnt
    );

    modport slave (
        input  in_valid, in_type, in_x, in_y, pop,
        output in_ready, out_valid, out_type, out_x, out_y,
               preview_valid, preview_type, count, reject_cnt
    );
endinterface

// File: rtl/piece_queue.sv
// Next-piece FIFO between the piece generator and the game controller.
// Optional repeat filter (drop a piece equal to the last written type): PIECE_QUEUE_NO_REPEAT_EN.
module piece_queue #(
    parameter int unsigned MAX_TYPES = 7,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CNT_W     = 3
) (
    input  logic         clk,
    input  logic         rst,
    piece_queue_if.slave q
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned TYPE_W = 3;
    localparam int unsigned POS_W  = 4;
    localparam int unsigned ENT_W  = TYPE_W + 2 * POS_W;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] nxt_ptr;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       reject_q, reject_d;
    logic             full, empty, take, type_ok, is_repeat;
    logic             wr_en, rej_en, pop_en;
    logic [ENT_W-1:0] head;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign take    = q.in_valid && !full;
    assign type_ok = (32'(q.in_type) < MAX_TYPES);
    assign wr_en   = take && type_ok && !is_repeat;
    // A discarded offer still completes the handshake, it just isn't stored.
    assign rej_en  = take && !wr_en;
    assign pop_en  = q.pop && !empty;

`ifdef PIECE_QUEUE_NO_REPEAT_EN
    logic [TYPE_W-1:0] last_type_q;
    logic              last_vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_type_q <= '0;
            last_vld_q  <= 1'b0;
        end else if (wr_en) begin
            last_type_q <= q.in_type;
            last_vld_q  <= 1'b1;
        end
    end

    assign is_repeat = last_vld_q && (q.in_type == last_type_q);
`else
    assign is_repeat = 1'b0;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        reject_d = reject_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop_en);
        if (rej_en && (reject_q != 8'hFF)) begin
            reject_d = reject_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            reject_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            reject_q <= reject_d;
        end
    end

    // Storage is not reset; contents are only observed through count gating.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {q.in_type, q.in_x, q.in_y};
        end
    end

    assign nxt_ptr = rd_ptr_q + PTR_W'(1);
    assign head    = mem_q[rd_ptr_q];

    assign q.in_ready      = !full;
    assign q.out_valid     = !empty;
    assign q.out_type      = empty ? '0 : head[ENT_W-1 -: TYPE_W];
    assign q.out_x         = empty ? '0 : head[2*POS_W-1 -: POS_W];
    assign q.out_y         = empty ? '0 : head[POS_W-1:0];
    assign q.preview_valid = (count_q >= CNT_W'(2));
    assign q.preview_type  = q.preview_valid ? mem_q[nxt_ptr][ENT_W-1 -: TYPE_W] : '0;
    assign q.count         = count_q;
    assign q.reject_cnt    = reject_q;
endmodule
